// File: rtl/branch_resolve_unit_pkg.sv
// ============================================================================
// Module   : branch_resolve_unit_pkg
// Purpose  : Condition codes, BHT counter encodings and counter update helper
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_resolve_unit_pkg;

    localparam int BR_COND_WIDTH = 3;

    localparam logic [BR_COND_WIDTH-1:0] BR_EQ  = 3'd0;
    localparam logic [BR_COND_WIDTH-1:0] BR_NE  = 3'd1;
    localparam logic [BR_COND_WIDTH-1:0] BR_LEZ = 3'd2;
    localparam logic [BR_COND_WIDTH-1:0] BR_GTZ = 3'd3;
    localparam logic [BR_COND_WIDTH-1:0] BR_LTZ = 3'd4;
    localparam logic [BR_COND_WIDTH-1:0] BR_GEZ = 3'd5;

    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Two-bit saturating counter step towards the resolved outcome
    function automatic logic [1:0] cnt_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == CNT_ST) ? CNT_ST : cnt + 2'd1;
        end
        return (cnt == CNT_SNT) ? CNT_SNT : cnt - 2'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/branch_cond.sv
// ============================================================================
// Module   : branch_cond
// Purpose  : Combinational evaluator for the MIPS conditional-branch set
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_cond
    import branch_resolve_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [BR_COND_WIDTH-1:0] cond,
    input  logic [DATA_W-1:0]        reg1,
    input  logic [DATA_W-1:0]        reg2,
    output logic                     taken
);

    // Sign-extended one bit so that equality never suffers from wrap-around
    logic [DATA_W:0] w_diff;
    logic            w_neg;
    logic            w_zero;

    assign w_diff = {reg1[DATA_W-1], reg1} - {reg2[DATA_W-1], reg2};
    assign w_neg  = reg1[DATA_W-1];
    assign w_zero = (reg1 == '0);

    always_comb begin
        taken = 1'b0;
        case (cond)
            BR_EQ:   taken = (w_diff == '0);
            BR_NE:   taken = (w_diff != '0);
            BR_LEZ:  taken = w_neg | w_zero;
            BR_GTZ:  taken = !w_neg & !w_zero;
            BR_LTZ:  taken = w_neg;
            BR_GEZ:  taken = !w_neg;
            default: taken = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Branch resolution, 2-bit BHT prediction/training, flush/redirect
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter int         DATA_W    = 32,
    parameter int         PC_W      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter logic [1:0] CNT_INIT  = CNT_WNT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic [PC_W-1:0]          pred_pc,
    output logic                     pred_taken,
    input  logic                     res_valid,
    input  logic                     res_stall,
    input  logic [BR_COND_WIDTH-1:0] res_cond,
    input  logic [PC_W-1:0]          res_pc,
    input  logic [PC_W-1:0]          res_target,
    input  logic                     res_pred_taken,
    input  logic [DATA_W-1:0]        reg1_data,
    input  logic [DATA_W-1:0]        reg2_data,
    output logic                     res_taken,
    output logic                     flush,
    output logic [PC_W-1:0]          redirect_pc,
    output logic [31:0]              branch_cnt,
    output logic [31:0]              mispredict_cnt
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic [1:0]       r_bht [BHT_DEPTH];
    logic [IDX_W-1:0] w_pred_idx;
    logic [IDX_W-1:0] w_res_idx;
    logic             w_act;
    logic             w_cond_taken;
    logic             w_unused_pc_bits;

    assign w_pred_idx       = pred_pc[IDX_W+1:2];
    assign w_res_idx        = res_pc[IDX_W+1:2];
    assign w_unused_pc_bits = ^{pred_pc, res_pc};

    branch_cond #(
        .DATA_W (DATA_W)
    ) u_cond (
        .cond  (res_cond),
        .reg1  (reg1_data),
        .reg2  (reg2_data),
        .taken (w_cond_taken)
    );

    assign w_act      = res_valid & !res_stall;
    assign res_taken  = w_act & w_cond_taken;
    assign flush      = w_act & (res_taken != res_pred_taken);
    assign pred_taken = pred_valid & r_bht[w_pred_idx][1];

    always_comb begin
        redirect_pc = '0;
        if (flush) begin
            redirect_pc = res_taken ? res_target : res_pc + PC_W'(4);
        end
    end

    // Lookup reads the array before this edge's write, so no bypass exists
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= CNT_INIT;
            end
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (w_act) begin
            r_bht[w_res_idx] <= cnt_next(r_bht[w_res_idx], res_taken);
            if (branch_cnt != '1) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (flush && (mispredict_cnt != '1)) begin
                mispredict_cnt <= mispredict_cnt + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire
